// File: rtl/counter_4bit.sv
// counter_4bit: WIDTH-bit unsigned up-counter with a level enable, an
// asynchronous clear and a registered one-cycle wrap flag. It is intended
// as a leaf event/cycle counter inside larger datapaths.
//
// The reset input keeps the codebase's historical name r_rst_n, but it is
// active-HIGH: a 1 on r_rst_n clears the counter.
module counter_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             r_clk,
  input  logic             r_rst_n,
  input  logic             i_enable,
  output logic [WIDTH-1:0] o_count,
  output logic             o_carry
);

  // Sized constants keep the increment and the wrap compare at exactly WIDTH bits.
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] CNT_MAX  = '1;

  // The edge that wraps all-ones to zero is the only one that raises carry.
  logic wrap_edge;
  assign wrap_edge = i_enable && (o_count == CNT_MAX);

  // Count and carry registers, cleared asynchronously while reset is high.
  // NOTE: reset appears in the sensitivity list so the clear takes effect
  // without a clock edge; state is updated with non-blocking assignments so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge r_clk or posedge r_rst_n) begin
    if (r_rst_n) begin
      o_count <= '0;
      o_carry <= 1'b0;
    end else begin
      if (i_enable) begin
        o_count <= o_count + CNT_ONE;
      end
      o_carry <= wrap_edge;
    end
  end

endmodule

// File: tb/tb_counter_4bit.sv
// Testbench for counter_4bit: a WIDTH=4 and a WIDTH=2 instance share the same
// clock, reset and enable. An integer-arithmetic reference model is compared
// against both every falling edge, and directed scenarios add literal checks.
module tb_counter_4bit;

  logic       r_clk    = 1'b0;
  logic       r_rst_n  = 1'b1;
  logic       i_enable = 1'b0;
  logic [3:0] count4;
  logic       carry4;
  logic [1:0] count2;
  logic       carry2;

  int total = 0;
  int bad   = 0;

  counter_4bit #(.WIDTH(4)) dut (
    .r_clk   (r_clk),
    .r_rst_n (r_rst_n),
    .i_enable(i_enable),
    .o_count (count4),
    .o_carry (carry4)
  );

  counter_4bit #(.WIDTH(2)) dut2 (
    .r_clk   (r_clk),
    .r_rst_n (r_rst_n),
    .i_enable(i_enable),
    .o_count (count2),
    .o_carry (carry2)
  );

  // 20 ns clock, first rising edge at 10 ns.
  always #10 r_clk = ~r_clk;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: plain integers, modulus 2**WIDTH, carry when the
  // incremented value reaches the modulus.
  int m_cnt4 = 0;
  int m_cnt2 = 0;
  int m_car4 = 0;
  int m_car2 = 0;

  always @(posedge r_clk or posedge r_rst_n) begin
    if (r_rst_n) begin
      m_cnt4 = 0; m_car4 = 0;
      m_cnt2 = 0; m_car2 = 0;
    end else if (i_enable) begin
      m_car4 = (m_cnt4 + 1 == 16) ? 1 : 0;
      m_cnt4 = (m_cnt4 + 1) % 16;
      m_car2 = (m_cnt2 + 1 == 4) ? 1 : 0;
      m_cnt2 = (m_cnt2 + 1) % 4;
    end else begin
      m_car4 = 0;
      m_car2 = 0;
    end
  end

  // Compare process, half a cycle away from the active edge.
  always @(negedge r_clk) begin
    check("model_count4", 32'(count4), 32'(m_cnt4));
    check("model_carry4", 32'(carry4), 32'(m_car4));
    check("model_count2", 32'(count2), 32'(m_cnt2));
    check("model_carry2", 32'(carry2), 32'(m_car2));
  end

  // One rising edge, then settle 2 ns before driving or sampling.
  task automatic step();
    @(posedge r_clk);
    #2;
  endtask

  // Hold reset for n edges with enable toggling; outputs must stay zero.
  task automatic do_reset(input int n);
    r_rst_n = 1'b1;
    #1;
    check("rst_assert_count", 32'(count4), 32'd0);
    for (int i = 0; i < n; i++) begin
      i_enable = ~i_enable;
      step();
      check("rst_hold_count", 32'(count4), 32'd0);
      check("rst_hold_carry", 32'(carry4), 32'd0);
    end
    i_enable = 1'b0;
    r_rst_n  = 1'b0;
  endtask

  initial begin
    // Power-on reset, checked before the first clock edge.
    #5;
    check("por_count_pre_edge", 32'(count4), 32'd0);
    check("por_carry_pre_edge", 32'(carry4), 32'd0);
    do_reset(4);

    // Short enable burst: 5 idle edges, 2 enabled edges, then hold at 2.
    repeat (5) step();
    check("burst_idle", 32'(count4), 32'd0);
    i_enable = 1'b1;
    step();
    check("burst_first", 32'(count4), 32'd1);
    step();
    check("burst_second", 32'(count4), 32'd2);
    i_enable = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check("burst_hold", 32'(count4), 32'd2);
      check("burst_carry", 32'(carry4), 32'd0);
    end

    // Free-run wrap: 20 enabled edges -> 1..15, 0, 1..4; WIDTH=2 instance
    // carries on edges 4, 8, 12, 16, 20.
    do_reset(3);
    i_enable = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      check("wrap_carry4", 32'(carry4), (k == 16) ? 32'd1 : 32'd0);
      check("wrap_carry2", 32'(carry2), (k % 4 == 0) ? 32'd1 : 32'd0);
      if (k == 15) check("wrap_at_max", 32'(count4), 32'd15);
      if (k == 16) check("wrap_to_zero", 32'(count4), 32'd0);
      if (k == 5)  check("w2_after_5", 32'(count2), 32'd1);
      if (k == 3)  check("w2_at_max", 32'(count2), 32'd3);
    end
    check("wrap_final", 32'(count4), 32'd4);
    i_enable = 1'b0;

    // Hold: count to 7, disable for 10 edges, enable for one edge -> 8.
    do_reset(3);
    i_enable = 1'b1;
    repeat (7) step();
    check("hold_reach7", 32'(count4), 32'd7);
    i_enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("hold_at7", 32'(count4), 32'd7);
    end
    i_enable = 1'b1;
    step();
    check("hold_then8", 32'(count4), 32'd8);
    i_enable = 1'b0;
    step();
    check("hold_after8", 32'(count4), 32'd8);

    // Asynchronous reset pulse mid-cycle while counting at 9.
    do_reset(3);
    i_enable = 1'b1;
    repeat (9) step();
    check("async_reach9", 32'(count4), 32'd9);
    r_rst_n = 1'b1;
    #1;
    check("async_clear_count", 32'(count4), 32'd0);
    check("async_clear_carry", 32'(carry4), 32'd0);
    #4;
    r_rst_n = 1'b0;
    #1;
    check("async_still0", 32'(count4), 32'd0);
    step();
    check("async_resume1", 32'(count4), 32'd1);
    step();
    check("async_resume2", 32'(count4), 32'd2);
    i_enable = 1'b0;

    // Enable toggling every cycle: each enabled edge adds exactly one.
    do_reset(3);
    for (int i = 0; i < 8; i++) begin
      i_enable = (i % 2 == 0);
      step();
    end
    check("toggle_count", 32'(count4), 32'd4);
    i_enable = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/counter_4bit.md
# counter_4bit

Synchronous up-counter, 4 bits wide by default, with a count-enable input and an asynchronous clear. The value advances by one on each rising clock edge where enable is high and holds otherwise. It wraps modulo 2^WIDTH and reports the wrap on a one-cycle carry flag. It is a leaf block used as an event or cycle counter inside larger datapaths; it has no handshake with neighbours beyond the enable level.

## Interface

- WIDTH, default 4: counter width in bits; legal range 1..32.
- r_clk  input  1  clock; all state updates on its rising edge.
- r_rst_n  input  1  reset, asynchronous, active-high; clock r_clk.
- i_enable  input  1  count enable, level-sensitive, sampled at the rising edge of r_clk.
- o_count  output  WIDTH  current count value, registered.
- o_carry  output  1  registered wrap flag; high for one cycle after a wrap.

## Operation

- State: one WIDTH-bit register driving o_count and one 1-bit register driving o_carry. No other state.
- Reset (r_rst_n = 1): o_count = 0 and o_carry = 0 immediately, without waiting for a clock edge. Both outputs hold 0 for as long as reset is high, and enable is ignored.
- Rising edge with reset low and i_enable = 1:
  - o_count <= o_count + 1, computed modulo 2^WIDTH.
  - The all-ones value wraps to 0. With WIDTH = 4, 15 goes to 0.
- Rising edge with reset low and i_enable = 0:
  - o_count holds its value.
- o_carry on each rising edge with reset low:
  - o_carry <= 1 only when the edge both is enabled and takes o_count from all-ones to 0.
  - On every other edge, o_carry <= 0.
- Arithmetic: the increment is unsigned at WIDTH bits. The overflow bit is dropped from o_count and appears only as o_carry.
- There is no load, no decrement and no saturation mode.
- Enable may be held high for any number of cycles. The counter then free-runs and wraps repeatedly.

## Timing

- Latency: the effect of i_enable appears on o_count one clock edge after the edge that samples it. o_count changes only just after the rising edge of r_clk.
- Reset assertion is asynchronous. Outputs go to 0 within propagation delay of r_rst_n rising, even mid-count or mid-cycle.
- Reset release: the first rising edge of r_clk after r_rst_n falls is a normal counting edge. The enable value at that edge applies.
- Reset and enable high together: reset wins and the count stays 0.
- Enable toggles per cycle: each enabled edge adds exactly 1 and each disabled edge adds 0. There is no dependence on enable history.
- o_carry is valid in the same cycle that o_count shows 0 after a wrap. It is deasserted on the following edge.
- The block is single-clock with no combinational paths from input to output.
- Timing is checked at a 50 MHz reference clock (20 ns period) with margin.

## Test plan

- Power-on reset: hold r_rst_n = 1 for at least 3 clock cycles with i_enable toggling -> o_count = 0 and o_carry = 0 throughout, including before the first clock edge.
- Short enable burst: release reset, wait 5 edges with i_enable = 0, then drive i_enable = 1 for exactly 2 rising edges, then 0 -> o_count steps 0, 1, 2 and then holds 2 for all remaining cycles; o_carry stays 0.
- Free-run wrap: release reset and hold i_enable = 1 for 20 edges -> o_count goes 1..15, 0, 1, 2, 3, 4. o_carry = 1 only in the cycle where o_count = 0, and 0 everywhere else.
- Hold behaviour: count up to 7, deassert enable for 10 edges, then enable for 1 edge -> o_count is 7 for all 10 cycles, then 8.
- Asynchronous reset mid-operation: while counting at 9 with enable high, pulse r_rst_n = 1 for 5 ns between clock edges -> o_count = 0 immediately, and counting resumes 1, 2, ... from the next enabled edge.
- Parameter check: WIDTH = 2 with enable held high -> sequence 1, 2, 3, 0, 1, with o_carry pulsing on each 3 -> 0 transition.
